carfield_hyper_cfg_init: RTL and testbench
==========================================

CARFIELD_HYPER_CFG_INIT -- requirements
Module: carfield_hyper_cfg_init

Interface
REQ-001 SHALL have parameter WaitCycles, default 1000: clk_i cycles between reset release and the first init write.
REQ-002 SHALL have parameter NumWrites, default 4: number of init table entries, range 0..16.
REQ-003 SHALL have parameter InitTable, default all-zero: array[NumWrites] of hyp_cfg_entry_t {addr, data}.
REQ-004 SHALL have parameters reg_req_t and reg_rsp_t, defaults carfield_reg_req_t and carfield_reg_rsp_t: register-bus request/response types.
REQ-005 SHALL have port clk_i, input, 1: single clock; all logic synchronous to its rising edge.
REQ-006 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port reinit_i, input, 1: one-cycle pulse requesting a re-run of the init sequence.
REQ-008 SHALL have port slv_req_i, input, reg_req_t: requests from the SoC register demux.
REQ-009 SHALL have port slv_rsp_o, output, reg_rsp_t: responses to the SoC.
REQ-010 SHALL have port mst_req_o, output, reg_req_t: requests to the HyperBus config port.
REQ-011 SHALL have port mst_rsp_i, input, reg_rsp_t: responses from the HyperBus config port.
REQ-012 SHALL have port init_done_o, input/output direction output, 1: init sequence finished and pass-through enabled.
REQ-013 SHALL have port init_err_o, output, 1: an init write returned error.
REQ-014 SHALL have port err_idx_o, output, 4: table index of the first failing write.

Function
REQ-015 SHALL use reg protocol semantics: a transfer completes in the cycle where valid and ready are both high; ready, rdata and error are valid only in that cycle.
REQ-016 SHALL implement FSM states WAIT, WRITE and DONE.
REQ-017 In WAIT, SHALL count from 0 to WaitCycles-1, then enter WRITE, or DONE when NumWrites=0; WaitCycles=0 SHALL leave WAIT after one cycle.
REQ-018 In WRITE, SHALL drive mst_req_o.valid=1, write=1, wstrb=4'hF, and addr/wdata=InitTable[idx], holding them stable until mst_rsp_i.ready.
REQ-019 On ready with error=0, SHALL increment idx; after entry NumWrites-1, SHALL enter DONE.
REQ-020 On ready with error=1, SHALL set init_err_o, latch err_idx_o=idx if init_err_o was 0, and enter DONE (abort the remaining entries).
REQ-021 In WAIT/WRITE, SHALL hold slv_rsp_o.ready=0 and keep slv_req_i off the master port (SoC stalls, no drop).
REQ-022 In DONE, SHALL combinationally pass slv_req_i to mst_req_o and mst_rsp_i to slv_rsp_o with zero latency; init_done_o=1.
REQ-023 A reinit_i pulse in any state SHALL set a pending flag.
REQ-024 The pending flag SHALL be consumed only in DONE in a cycle with slv_req_i.valid=0; the module SHALL then clear init_done_o, reset the counter and idx, and enter WAIT.
REQ-025 If slv_req_i.valid=1 when reinit is pending, SHALL complete the SoC transfer first; the reinit SHALL NOT truncate an in-progress SoC transfer.
REQ-026 init_err_o/err_idx_o SHALL be sticky across reinit and clear only on rst_ni.
REQ-027 The wait counter SHALL be $clog2(WaitCycles+1) bits with no wrap; idx SHALL be 4 bits.
REQ-028 mst_req_o SHALL be all-zero outside WRITE and DONE.

Reset
REQ-029 On rst_ni low: state=WAIT, counter=0, idx=0, pending=0, init_done_o=0, init_err_o=0, err_idx_o=0, mst_req_o.valid=0, slv_rsp_o.ready=0.
REQ-030 Reset assertion mid-write SHALL drop the write immediately; after release, the sequence SHALL restart from WAIT.

Structure
REQ-031 carfield_pkg SHALL define hyp_cfg_entry_t (addr: 48 bits, data: 32 bits), HypCfgMaxWrites=16 and the default HypCfgInitTable.
REQ-032 SHALL be a single module with no sub-modules; the top level SHALL instantiate it between the cheshire_soc reg-ext port and the HyperBus reg port.

Verification
REQ-033 WaitCycles=10, NumWrites=2, table {0x0:0xA, 0x4:0xB}, ready=1 always -> writes at cycles 10 and 11 after reset, init_done_o=1 at cycle 12.
REQ-034 SoC read at cycle 3 of scenario REQ-033 -> stalled with ready=0; completes once in DONE with the HyperBus rdata.
REQ-035 Entry 1 of 3 returns error=1 -> init_err_o=1, err_idx_o=1, entry 2 never issued, init_done_o=1.
REQ-036 Slave ready delayed 5 cycles per write -> addr/wdata stable throughout, exactly one handshake per entry.
REQ-037 reinit_i while a SoC transfer is pending in DONE -> transfer completes, next cycle WAIT, init_done_o=0, full table replayed.
REQ-038 rst_ni asserted during WRITE of entry 1 -> outputs at reset values asynchronously; after release, sequence restarts at entry 0.

Source files
------------

// File: rtl/carfield_pkg.sv
// Shared types for the Carfield HyperBus config-init path: register-bus
// structs, the init-table entry type and the init FSM state encoding.
package carfield_pkg;

  localparam int unsigned HypCfgMaxWrites = 16;

  typedef struct packed {
    logic [47:0] addr;
    logic [31:0] data;
  } hyp_cfg_entry_t;

  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } carfield_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } carfield_reg_rsp_t;

  typedef enum logic [1:0] {
    HypWait  = 2'd0,
    HypWrite = 2'd1,
    HypDone  = 2'd2
  } hyp_cfg_state_e;

  localparam hyp_cfg_entry_t HypCfgInitTable [HypCfgMaxWrites] = '{default: '0};

endpackage

// File: rtl/carfield_hyper_cfg_init.sv
// Replays a fixed table of register writes into the HyperBus config port after
// reset (or on request), then becomes a zero-latency pass-through for the SoC.
module carfield_hyper_cfg_init
  import carfield_pkg::*;
#(
  parameter int unsigned    WaitCycles = 1000,
  parameter int unsigned    NumWrites  = 4,
  parameter hyp_cfg_entry_t InitTable [HypCfgMaxWrites] = HypCfgInitTable,
  parameter type            reg_req_t  = carfield_reg_req_t,
  parameter type            reg_rsp_t  = carfield_reg_rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       reinit_i,
  input  reg_req_t   slv_req_i,
  output reg_rsp_t   slv_rsp_o,
  output reg_req_t   mst_req_o,
  input  reg_rsp_t   mst_rsp_i,
  output logic       init_done_o,
  output logic       init_err_o,
  output logic [3:0] err_idx_o
);

  localparam int unsigned CntW = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;

  hyp_cfg_state_e  state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      idx_q;
  logic [3:0]      err_idx_q;
  logic            pend_q;
  logic            err_q;

  logic wait_last_s;
  logic last_entry_s;
  logic consume_s;

  // The +1 form lets WaitCycles=0 leave WAIT after a single cycle.
  assign wait_last_s  = (32'(cnt_q) + 32'd1) >= WaitCycles;
  assign last_entry_s = (32'(idx_q) + 32'd1) >= NumWrites;
  // A pending reinit waits for an idle SoC port so no transfer is cut short.
  assign consume_s    = (state_q == HypDone) && pend_q && !slv_req_i.valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= HypWait;
      cnt_q     <= '0;
      idx_q     <= 4'd0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= 4'd0;
    end else begin
      pend_q <= reinit_i | (pend_q & ~consume_s);
      case (state_q)
        HypWait: begin
          if (wait_last_s) begin
            cnt_q <= '0;
            idx_q <= 4'd0;
            if (NumWrites == 0) begin
              state_q <= HypDone;
            end else begin
              state_q <= HypWrite;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        HypWrite: begin
          if (mst_rsp_i.ready) begin
            if (mst_rsp_i.error) begin
              err_q <= 1'b1;
              if (!err_q) begin
                err_idx_q <= idx_q;
              end
              state_q <= HypDone;
            end else if (last_entry_s) begin
              state_q <= HypDone;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        HypDone: begin
          if (consume_s) begin
            state_q <= HypWait;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
          end
        end
        default: begin
          state_q <= HypWait;
        end
      endcase
    end
  end

  // Bus steering: table write in WRITE, transparent link in DONE, quiet otherwise.
  always_comb begin
    mst_req_o = '0;
    slv_rsp_o = '0;
    case (state_q)
      HypWrite: begin
        mst_req_o.valid = 1'b1;
        mst_req_o.write = 1'b1;
        mst_req_o.wstrb = 4'hF;
        mst_req_o.addr  = InitTable[idx_q].addr;
        mst_req_o.wdata = InitTable[idx_q].data;
      end
      HypDone: begin
        mst_req_o = slv_req_i;
        slv_rsp_o = mst_rsp_i;
      end
      default: begin
        mst_req_o = '0;
        slv_rsp_o = '0;
      end
    endcase
  end

  assign init_done_o = (state_q == HypDone);
  assign init_err_o  = err_q;
  assign err_idx_o   = err_idx_q;

endmodule

// File: tb/tb_carfield_hyper_cfg_init.sv
// Scoreboard bench: stimulus queues expected master/SoC transfers, a negedge
// monitor pops and compares them against what the DUT actually presents.
module tb_carfield_hyper_cfg_init;
  import carfield_pkg::*;

  localparam int unsigned TbWait = 10;
  localparam int unsigned TbN    = 3;
  localparam hyp_cfg_entry_t TbTable [HypCfgMaxWrites] = '{
    0: '{addr: 48'h0, data: 32'hA},
    1: '{addr: 48'h4, data: 32'hB},
    2: '{addr: 48'h8, data: 32'hC},
    default: '{addr: 48'h0, data: 32'h0}
  };

  typedef struct {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          cyc;
  } mst_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reinit = 1'b0;
  carfield_reg_req_t slv_req, mst_req;
  carfield_reg_rsp_t slv_rsp, mst_rsp;
  logic init_done, init_err;
  logic [3:0] err_idx;

  int checks = 0;
  int failures = 0;
  int cyc;
  int wcnt;
  int lat = 0;
  int hs_cnt = 0;
  logic err_en = 1'b0;
  logic [47:0] err_addr = 48'h0;
  bit chk_timing = 1'b0;
  mst_exp_t mst_q[$];
  logic [31:0] soc_q[$];

  always #5 clk = ~clk;

  carfield_hyper_cfg_init #(
    .WaitCycles(TbWait),
    .NumWrites (TbN),
    .InitTable (TbTable)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .reinit_i   (reinit),
    .slv_req_i  (slv_req),
    .slv_rsp_o  (slv_rsp),
    .mst_req_o  (mst_req),
    .mst_rsp_i  (mst_rsp),
    .init_done_o(init_done),
    .init_err_o (init_err),
    .err_idx_o  (err_idx)
  );

  function automatic logic [31:0] slv_rdata(input logic [47:0] a);
    return 32'hCAFE0000 ^ {16'h0, a[15:0]};
  endfunction

  // HyperBus config-port model: ready after lat wait cycles, error on err_addr.
  always_comb begin
    mst_rsp = '0;
    if (mst_req.valid && (wcnt >= lat)) begin
      mst_rsp.ready = 1'b1;
      mst_rsp.rdata = mst_req.write ? 32'h0 : slv_rdata(mst_req.addr);
      mst_rsp.error = err_en && mst_req.write && (mst_req.addr == err_addr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0;
      cyc  <= 0;
    end else begin
      cyc <= cyc + 1;
      if (mst_req.valid && !mst_rsp.ready) wcnt <= wcnt + 1;
      else wcnt <= 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, stall/stability rules and init timing.
  initial begin
    mst_exp_t e;
    logic [47:0] prev_addr;
    logic [31:0] prev_wdata;
    bit prev_stall;
    prev_stall = 1'b0;
    prev_addr = 48'h0;
    prev_wdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mst_req.valid && mst_rsp.ready) begin
          hs_cnt++;
          if (mst_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mst_unexpected: got addr 0x%0h expected no transfer", mst_req.addr);
          end else begin
            e = mst_q.pop_front();
            check("mst_addr", 64'(mst_req.addr), 64'(e.addr));
            check("mst_write", 64'(mst_req.write), 64'(e.write));
            if (e.write) check("mst_wdata", 64'(mst_req.wdata), 64'(e.wdata));
            if (e.cyc >= 0) check("mst_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
        if (slv_req.valid && slv_rsp.ready) begin
          if (soc_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL soc_unexpected: got rdata 0x%0h expected no response", slv_rsp.rdata);
          end else begin
            check("soc_rdata", 64'(slv_rsp.rdata), 64'(soc_q.pop_front()));
          end
        end
        if (prev_stall && mst_req.valid) begin
          check("stable_addr", 64'(mst_req.addr), 64'(prev_addr));
          check("stable_wdata", 64'(mst_req.wdata), 64'(prev_wdata));
        end
        if (!init_done && slv_req.valid)
          check("soc_stall", 64'({slv_rsp.ready, (~mst_req.valid) | mst_req.write}), 64'(2'b01));
        if (chk_timing && (cyc == TbWait + TbN - 1)) check("done_early", 64'(init_done), 64'(0));
        if (chk_timing && (cyc == TbWait + TbN)) check("done_time", 64'(init_done), 64'(1));
        prev_stall = mst_req.valid && !mst_rsp.ready;
        prev_addr  = mst_req.addr;
        prev_wdata = mst_req.wdata;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic push_writes(input int n, input int base);
    for (int i = 0; i < n; i++)
      mst_q.push_back('{addr: TbTable[i].addr, write: 1'b1, wdata: TbTable[i].data,
                        cyc: (base < 0) ? -1 : base + i});
  endtask

  task automatic soc_read(input logic [47:0] a);
    bit ok;
    ok = 1'b0;
    soc_q.push_back(slv_rdata(a));
    mst_q.push_back('{addr: a, write: 1'b0, wdata: 32'h0, cyc: -1});
    slv_req = '0;
    slv_req.addr = a;
    slv_req.valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (slv_rsp.ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("soc_complete", 64'(ok), 64'(1));
    @(posedge clk);
    #1 slv_req = '0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (init_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_reached", 64'(ok), 64'(1));
  endtask

  task automatic pulse_reinit();
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1 reinit = 1'b1;
    @(posedge clk);
    #1 reinit = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (!init_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reinit_taken", 64'(ok), 64'(1));
  endtask

  initial begin
    bit ok;
    int hs0;
    slv_req = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 64'(init_done), 64'(0));
    check("rst_err", 64'(init_err), 64'(0));
    check("rst_err_idx", 64'(err_idx), 64'(0));
    check("rst_mst_valid", 64'(mst_req.valid), 64'(0));
    check("rst_slv_ready", 64'(slv_rsp.ready), 64'(0));

    // Nominal sequence with a SoC read stalled from cycle 3 until DONE.
    push_writes(TbN, TbWait);
    chk_timing = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20 && cyc < 3; n++) @(negedge clk);
    soc_read(48'h100);
    wait_done(50);
    chk_timing = 1'b0;
    check("no_err", 64'(init_err), 64'(0));

    // Entry 1 fails: abort, entry 2 never issued.
    err_en = 1'b1;
    err_addr = 48'h4;
    pulse_reinit();
    push_writes(2, -1);
    wait_done(100);
    check("err_flag", 64'(init_err), 64'(1));
    check("err_idx", 64'(err_idx), 64'(1));
    repeat (3) @(negedge clk);
    check("err_abort_q", 64'(mst_q.size()), 64'(0));

    // Slow slave: five wait cycles per write, one handshake per entry.
    err_en = 1'b0;
    lat = 5;
    hs0 = hs_cnt;
    pulse_reinit();
    push_writes(TbN, -1);
    wait_done(200);
    check("slow_hs_count", 64'(hs_cnt - hs0), 64'(TbN));
    check("err_sticky", 64'(init_err), 64'(1));
    check("err_idx_sticky", 64'(err_idx), 64'(1));

    // Reinit while a SoC read is in flight in DONE.
    lat = 3;
    fork
      soc_read(48'h2A0);
      begin
        @(posedge clk);
        #1 reinit = 1'b1;
        @(posedge clk);
        #1 reinit = 1'b0;
      end
    join
    lat = 0;
    push_writes(TbN, -1);
    @(negedge clk);
    check("reinit_hold", 64'(init_done), 64'(1));
    @(negedge clk);
    check("reinit_wait", 64'(init_done), 64'(0));
    wait_done(100);

    // Reset asserted while entry 1 is waiting for ready.
    lat = 5;
    pulse_reinit();
    push_writes(1, -1);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (mst_req.valid && (mst_req.addr == 48'h4)) begin
        ok = 1'b1;
        break;
      end
    end
    check("entry1_seen", 64'(ok), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mst_valid", 64'(mst_req.valid), 64'(0));
    check("arst_done", 64'(init_done), 64'(0));
    check("arst_err", 64'(init_err), 64'(0));
    check("arst_err_idx", 64'(err_idx), 64'(0));
    check("arst_slv_ready", 64'(slv_rsp.ready), 64'(0));
    check("arst_q_empty", 64'(mst_q.size()), 64'(0));
    lat = 0;
    repeat (2) @(posedge clk);
    push_writes(TbN, TbWait);
    chk_timing = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(50);
    chk_timing = 1'b0;

    repeat (2) @(negedge clk);
    check("end_mst_q", 64'(mst_q.size()), 64'(0));
    check("end_soc_q", 64'(soc_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
